coproc_ctrl: RTL and testbench
==============================

COPROC_CTRL -- requirements
Module: coproc_ctrl

Interface
REQ-001 Parameter INSTR_W, default 32: instruction word width.
REQ-002 Parameter ADDR_W, default 8: memory address field width.
REQ-003 Parameter DATA_W, default 8: data/scalar field width.
REQ-004 Parameter FIFO_DEPTH, default 4: instruction queue depth, power of two, at least 2.
REQ-005 Parameter TIMEOUT, default 1023: maximum EXECUTE cycles without done.
REQ-006 The design SHALL use one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-007 Ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- instr  in  INSTR_W  instruction word.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  queue not full.
- mem_start  out  1  memory operation request.
- mem_wr  out  1  1=WRITE, 0=READ.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_done  in  1  memory completion pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_done.
- alu_start  out  1  ALU operation request.
- alu_op  out  4  ALU opcode.
- alu_scalar  out  DATA_W  scalar operand (MULSCL).
- alu_done  in  1  ALU completion pulse.
- retire_valid  out  1  one-cycle retire pulse.
- retire_opcode  out  4  opcode of retired instruction.
- retire_data  out  DATA_W  READ result, else 0.
- retire_err  out  2  00 ok, 01 illegal opcode, 10 timeout.
- busy  out  1  high unless IDLE with empty queue.
- fifo_level  out  clog2(FIFO_DEPTH+1)  queued instruction count.

Function
REQ-008 Field layout: opcode = instr[3:0]; address = instr[4+ADDR_W-1:4]; data = the next DATA_W bits above address.
REQ-009 Opcodes: READ=1, WRITE=2 (memory); SUM=3 through DET5=12 (ALU); 0 and 13-15 are illegal.
REQ-010 Instruction accepted on a clock edge where instr_valid and instr_ready are both high; instr_ready = not full.
REQ-011 The FIFO SHALL handle a simultaneous push and pop with fifo_level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-012 FSM states: IDLE, DECODE, EXECUTE, RETIRE.
REQ-013 IDLE: if the queue is non-empty, pop the head into the instruction register and go to DECODE; otherwise stay.
REQ-014 DECODE: if the opcode is legal, go to EXECUTE with the timeout counter cleared; if illegal, go to RETIRE with err=01 and no start.
REQ-015 EXECUTE: mem_start (opcodes 1-2) or alu_start (3-12) SHALL be high every EXECUTE cycle and low in all other states; never both.
REQ-016 In EXECUTE, only the selected target's done counts; a done from the other module SHALL be ignored.
REQ-017 Target done in EXECUTE leads to RETIRE with err=00; for READ, retire_data captures mem_rdata.
REQ-018 The timeout counter SHALL increment each EXECUTE cycle without done; reaching TIMEOUT leads to RETIRE with err=10. Done in the same cycle as expiry SHALL count as success.
REQ-019 RETIRE: retire_valid high for exactly one cycle with opcode, data and err, then go to IDLE.
REQ-020 Minimum latency: an instruction accepted at edge k into an empty queue in IDLE SHALL raise start after edge k+2; done at edge d gives retire_valid after edge d+1.
REQ-021 mem_addr, mem_wdata, alu_op and alu_scalar SHALL hold stable from DECODE through RETIRE.
REQ-022 The queue accepts instructions in every state; execution is strictly in order, one at a time.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, empty the queue, and drive every output to 0 except instr_ready=1; this applies mid-operation, including EXECUTE with start high.
REQ-024 A done pulse arriving during or after reset SHALL be ignored until a new EXECUTE.

Structure
REQ-025 Opcode constants, the retire_err encoding and the state encoding SHALL live in a shared package, coproc_pkg.
REQ-026 The queue SHALL be one sub-module, coproc_instr_fifo, parametrised by width and depth.

Verification
REQ-027 WRITE addr 0x05 data 0xA3; mem_done after 4 cycles -> mem_start high 4 cycles, mem_wr=1, retire err=00, retire_data=0.
REQ-028 READ addr 0x10; mem_done with mem_rdata=0x5C -> retire_opcode=1, retire_data=0x5C, err=00.
REQ-029 Opcode 14 -> no start pulse, retire err=01 two edges after pop.
REQ-030 TIMEOUT=8, SUM with alu_done never asserted -> alu_start high 8 cycles, retire err=10; next queued instruction then executes.
REQ-031 Push 5 instructions back-to-back with depth 4 -> instr_ready low when full, fifo_level never exceeds 4, all retire in order.
REQ-032 Assert rst_n=0 mid-EXECUTE with 3 queued -> starts drop immediately, fifo_level=0, no retire pulse, busy=0.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared constants for the coprocessor controller: opcodes, retire error codes,
// controller states and opcode classification helpers.
package coproc_pkg;

    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_WRITE = 4'd2;
    localparam logic [3:0] OP_SUM   = 4'd3;
    localparam logic [3:0] OP_DET5  = 4'd12;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_RETIRE  = 2'd3
    } state_e;

    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

    function automatic logic op_is_alu(input logic [3:0] op);
        return (op >= OP_SUM) && (op <= OP_DET5);
    endfunction

endpackage

// File: rtl/coproc_instr_fifo.sv
// Instruction queue: power-of-two depth, single clock, show-ahead read port.
// Push is dropped when full, pop is dropped when empty.
module coproc_instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/coproc_ctrl.sv
// Coprocessor controller: queues instructions, dispatches them one at a time to
// the memory or ALU unit, applies a completion timeout and retires in order.
module coproc_ctrl
    import coproc_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [INSTR_W-1:0]              instr,
    input  logic                            instr_valid,
    output logic                            instr_ready,
    output logic                            mem_start,
    output logic                            mem_wr,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic                            mem_done,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic                            alu_start,
    output logic [3:0]                      alu_op,
    output logic [DATA_W-1:0]               alu_scalar,
    input  logic                            alu_done,
    output logic                            retire_valid,
    output logic [3:0]                      retire_opcode,
    output logic [DATA_W-1:0]               retire_data,
    output logic [1:0]                      retire_err,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int IR_W  = 4 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    err_e               err_q, err_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [IR_W-1:0]    fifo_dout;
    logic [3:0]         op;
    logic               is_mem, is_alu, tgt_done;

    // Only the opcode/address/data fields are queued; upper word bits are don't-care.
    generate
        if (INSTR_W > IR_W) begin : g_unused_hi
            logic unused_instr_hi;
            assign unused_instr_hi = ^instr[INSTR_W-1:IR_W];
        end
    endgenerate

    coproc_instr_fifo #(
        .WIDTH (IR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (instr_valid),
        .push_data (instr[IR_W-1:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign op       = ir_q[3:0];
    assign is_mem   = op_is_mem(op);
    assign is_alu   = op_is_alu(op);
    assign tgt_done = is_mem ? mem_done : alu_done;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ir_d     = fifo_dout;
                    rdata_d  = '0;
                    err_d    = ERR_OK;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_mem || is_alu) begin
                    cnt_d   = '0;
                    state_d = ST_EXECUTE;
                end else begin
                    err_d   = ERR_ILLEGAL;
                    state_d = ST_RETIRE;
                end
            end
            ST_EXECUTE: begin
                // Completion wins over a timeout expiring in the same cycle.
                if (tgt_done) begin
                    err_d   = ERR_OK;
                    if (op == OP_READ) rdata_d = mem_rdata;
                    state_d = ST_RETIRE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RETIRE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RETIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign instr_ready   = !fifo_full;
    assign mem_start     = (state_q == ST_EXECUTE) && is_mem;
    assign alu_start     = (state_q == ST_EXECUTE) && is_alu;
    assign mem_wr        = (op == OP_WRITE);
    assign mem_addr      = ir_q[4 +: ADDR_W];
    assign mem_wdata     = ir_q[4+ADDR_W +: DATA_W];
    assign alu_op        = op;
    assign alu_scalar    = ir_q[4+ADDR_W +: DATA_W];
    assign retire_valid  = (state_q == ST_RETIRE);
    assign retire_opcode = retire_valid ? op : 4'd0;
    assign retire_data   = retire_valid ? rdata_q : '0;
    assign retire_err    = retire_valid ? err_q : ERR_OK;
    assign busy          = !((state_q == ST_IDLE) && fifo_empty);

endmodule

// File: tb/tb_coproc_ctrl.sv
// Directed bench for coproc_ctrl with TIMEOUT=8: latency, memory/ALU dispatch,
// illegal opcode, timeout, queue full, in-order retire and async reset.
module tb_coproc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_start, mem_wr;
    logic [7:0]  mem_addr, mem_wdata;
    logic        mem_done;
    logic [7:0]  mem_rdata;
    logic        alu_start;
    logic [3:0]  alu_op;
    logic [7:0]  alu_scalar;
    logic        alu_done;
    logic        retire_valid;
    logic [3:0]  retire_opcode;
    logic [7:0]  retire_data;
    logic [1:0]  retire_err;
    logic        busy;
    logic [2:0]  fifo_level;

    int errs = 0;
    int checks = 0;
    logic       auto_done = 1'b0;
    logic [3:0] ret_op[$];
    logic [7:0] ret_data[$];
    logic [1:0] ret_err[$];
    int         max_level = 0;

    coproc_ctrl #(
        .INSTR_W(32), .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_start(mem_start), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .alu_start(alu_start), .alu_op(alu_op),
        .alu_scalar(alu_scalar), .alu_done(alu_done), .retire_valid(retire_valid),
        .retire_opcode(retire_opcode), .retire_data(retire_data),
        .retire_err(retire_err), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d);
        return {12'd0, d, a, op};
    endfunction

    task automatic push(input logic [31:0] w);
        int n = 0;
        instr = w;
        instr_valid = 1'b1;
        while (!instr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("push_wait_expired", 32'd1, 32'd0);
        tick();
        instr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (retire_valid) begin
            ret_op.push_back(retire_opcode);
            ret_data.push_back(retire_data);
            ret_err.push_back(retire_err);
        end
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end

    // Memory model used for the in-order test: one-cycle completion, rdata = addr ^ 0x80.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_done) begin
            mem_done  = mem_start && !mem_done;
            mem_rdata = mem_addr ^ 8'h80;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int n;
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
        mem_done = 1'b0; mem_rdata = '0; alu_done = 1'b0;
        tick(); tick();
        chk("rst_ready", instr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_starts", {mem_start, alu_start, retire_valid}, 0);
        rst_n = 1'b1;
        tick(); tick();

        // WRITE 0x05 <- 0xA3, done after 4 start cycles; stray alu_done ignored
        instr = mk(4'd2, 8'h05, 8'hA3); instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        chk("wr_level_after_push", fifo_level, 1);
        chk("wr_no_start_k", mem_start, 0);
        tick();
        chk("wr_decode_nostart", mem_start, 0);
        chk("wr_decode_busy", busy, 1);
        chk("wr_decode_addr", mem_addr, 8'h05);
        tick();
        chk("wr_exec_start", mem_start, 1);
        chk("wr_exec_wr", mem_wr, 1);
        chk("wr_exec_wdata", mem_wdata, 8'hA3);
        chk("wr_exec_alu_off", alu_start, 0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("wr_ignore_alu_done", {mem_start, retire_valid}, 2'b10);
        tick();
        chk("wr_start_c3", mem_start, 1);
        tick();
        chk("wr_start_c4", mem_start, 1);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("wr_retire", {retire_valid, retire_opcode, retire_err}, {1'b1, 4'd2, 2'b00});
        chk("wr_retire_data", retire_data, 0);
        chk("wr_retire_start_off", mem_start, 0);
        chk("wr_retire_addr", mem_addr, 8'h05);
        tick();
        chk("wr_idle", {retire_valid, busy}, 0);

        // READ 0x10 returning 0x5C
        push(mk(4'd1, 8'h10, 8'h00));
        tick(); tick();
        chk("rd_exec", {mem_start, mem_wr, mem_addr}, {1'b1, 1'b0, 8'h10});
        mem_done = 1'b1; mem_rdata = 8'h5C;
        tick();
        mem_done = 1'b0; mem_rdata = 8'h00;
        chk("rd_retire", {retire_valid, retire_opcode, retire_err}, {1'b1, 4'd1, 2'b00});
        chk("rd_retire_data", retire_data, 8'h5C);
        tick();

        // Illegal opcode 14: no start, retire two edges after the pop
        push(mk(4'd14, 8'h00, 8'h00));
        tick();
        chk("ill_decode", {mem_start, alu_start, retire_valid}, 0);
        tick();
        chk("ill_retire", {retire_valid, retire_opcode, retire_err}, {1'b1, 4'd14, 2'b01});
        chk("ill_nostart", {mem_start, alu_start}, 0);
        tick();

        // SUM times out after 8 cycles; queued WRITE then runs. Push overlaps pop.
        instr = mk(4'd3, 8'h33, 8'h44); instr_valid = 1'b1;
        tick();
        instr = mk(4'd2, 8'h07, 8'h11);
        tick();
        instr_valid = 1'b0;
        chk("to_level_push_pop", fifo_level, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_alu_start_%0d", i), {alu_start, mem_start}, 2'b10);
            mem_done = (i == 2);
            tick();
        end
        mem_done = 1'b0;
        chk("to_retire", {retire_valid, retire_opcode, retire_err}, {1'b1, 4'd3, 2'b10});
        chk("to_retire_start_off", alu_start, 0);
        chk("to_alu_fields", {alu_op, alu_scalar}, {4'd3, 8'h44});
        tick(); tick(); tick();
        chk("to_next_exec", {mem_start, mem_addr, mem_wdata}, {1'b1, 8'h07, 8'h11});
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("to_next_retire", {retire_valid, retire_opcode, retire_err}, {1'b1, 4'd2, 2'b00});
        tick();

        // Five back-to-back READs: queue fills, then all retire in order
        ret_op.delete(); ret_data.delete(); ret_err.delete(); max_level = 0;
        for (int i = 1; i <= 5; i++) push(mk(4'd1, 8'(i), 8'h00));
        chk("full_ready_low", instr_ready, 0);
        chk("full_level", fifo_level, 4);
        auto_done = 1'b1;
        n = 0;
        while (ret_op.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        auto_done = 1'b0;
        tick();
        mem_done = 1'b0;
        chk("order_count", ret_op.size(), 5);
        for (int i = 0; i < ret_op.size() && i < 5; i++) begin
            chk($sformatf("order_%0d", i), {ret_op[i], ret_data[i], ret_err[i]},
                {4'd1, 8'(i + 1) ^ 8'h80, 2'b00});
        end
        chk("max_level", max_level, 4);

        // Reset mid-EXECUTE with 3 queued; done during and after reset ignored
        for (int i = 0; i < 4; i++) push(mk(4'd1, 8'(8'h21 + i), 8'h00));
        chk("rst_pre_exec", {mem_start, fifo_level}, {1'b1, 3'd3});
        n0 = ret_op.size();
        rst_n = 1'b0;
        mem_done = 1'b1;
        #1;
        chk("rst_mid_starts", {mem_start, alu_start, retire_valid}, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_busy_ready", {busy, instr_ready}, 2'b01);
        chk("rst_mid_addr", mem_addr, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        mem_done = 1'b0;
        tick();
        chk("rst_post_busy", busy, 0);
        chk("rst_post_no_retire", ret_op.size(), n0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
